// File: rtl/jcu_pkg.sv
// Shared constants for the jump control unit: ALU opcodes, condition codes,
// load-source codes, control-word bit positions and the NOP word.
package jcu_pkg;

    localparam int CW_W = 55;

    localparam logic [3:0] ALU_LEFT = 4'h0;
    localparam logic [3:0] ALU_IADD = 4'h1;

    localparam logic [1:0] COND_Z = 2'h0;
    localparam logic [1:0] COND_S = 2'h1;
    localparam logic [1:0] COND_O = 2'h2;
    localparam logic [1:0] COND_E = 2'h3;

    localparam logic [1:0] LD_NONE = 2'b00;
    localparam logic [1:0] LD_PC   = 2'b01;

    // Control-word field positions, MSB first.
    localparam int PC_INC_BIT  = 54;
    localparam int OP_HI       = 53;
    localparam int OP_LO       = 50;
    localparam int A_ALT_HI    = 49;
    localparam int A_ALT_LO    = 34;
    localparam int B_ALT_HI    = 33;
    localparam int B_ALT_LO    = 18;
    localparam int A_SEL_HI    = 17;
    localparam int A_SEL_LO    = 14;
    localparam int B_SEL_HI    = 13;
    localparam int B_SEL_LO    = 10;
    localparam int A_SRC_BIT   = 9;
    localparam int B_SRC_BIT   = 8;
    localparam int OUT_SEL_HI  = 7;
    localparam int OUT_SEL_LO  = 4;
    localparam int LD_HI       = 3;
    localparam int LD_LO       = 2;
    localparam int STK_BIT     = 1;
    localparam int MEM_BIT     = 0;

    localparam logic [CW_W-1:0] CW_NOP = {1'b1, {(CW_W-1){1'b0}}};

    function automatic logic [CW_W-1:0] pack_word(
        input logic        pc_inc,
        input logic [3:0]  op,
        input logic [15:0] a_alt,
        input logic [15:0] b_alt,
        input logic [3:0]  a_sel,
        input logic [3:0]  b_sel,
        input logic        a_src,
        input logic        b_src,
        input logic [3:0]  out_sel,
        input logic [1:0]  load_src,
        input logic        stk,
        input logic        mem
    );
        return {pc_inc, op, a_alt, b_alt, a_sel, b_sel, a_src, b_src,
                out_sel, load_src, stk, mem};
    endfunction

endpackage

// File: rtl/jcu_word_unpack.sv
// Purely combinational split of a 55-bit ALU/PC control word into its fields;
// usable by any decoder that emits the same word layout.
module jcu_word_unpack
    import jcu_pkg::*;
(
    input  logic [CW_W-1:0] word,
    output logic            program_counter_increment,
    output logic [3:0]      alu_op,
    output logic [15:0]     alu_a_altern,
    output logic [15:0]     alu_b_altern,
    output logic [3:0]      alu_a_select,
    output logic [3:0]      alu_b_select,
    output logic            alu_a_source,
    output logic            alu_b_source,
    output logic [3:0]      alu_out_select,
    output logic [1:0]      alu_load_src,
    output logic            alu_store_to_stk,
    output logic            alu_store_to_mem
);

    assign program_counter_increment = word[PC_INC_BIT];
    assign alu_op           = word[OP_HI:OP_LO];
    assign alu_a_altern     = word[A_ALT_HI:A_ALT_LO];
    assign alu_b_altern     = word[B_ALT_HI:B_ALT_LO];
    assign alu_a_select     = word[A_SEL_HI:A_SEL_LO];
    assign alu_b_select     = word[B_SEL_HI:B_SEL_LO];
    assign alu_a_source     = word[A_SRC_BIT];
    assign alu_b_source     = word[B_SRC_BIT];
    assign alu_out_select   = word[OUT_SEL_HI:OUT_SEL_LO];
    assign alu_load_src     = word[LD_HI:LD_LO];
    assign alu_store_to_stk = word[STK_BIT];
    assign alu_store_to_mem = word[MEM_BIT];

endmodule

// File: rtl/jump_control_unit.sv
// Conditional-jump decoder: one registered stage from instruction + flags to
// control word. Define JCU_ERROR_COND_EN to make cond 11 test errorbit[t].
module jump_control_unit
    import jcu_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int SEL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [11:0]          instruction,
    input  logic [REG_COUNT-1:0] zeroflag,
    input  logic [REG_COUNT-1:0] signflag,
    input  logic [REG_COUNT-1:0] overflow,
    input  logic [REG_COUNT-1:0] errorbit,
    output logic [CW_W-1:0]      control_word,
    output logic                 program_counter_increment,
    output logic [3:0]           alu_op,
    output logic [15:0]          alu_a_altern,
    output logic [15:0]          alu_b_altern,
    output logic [3:0]           alu_a_select,
    output logic [3:0]           alu_b_select,
    output logic                 alu_a_source,
    output logic                 alu_b_source,
    output logic [3:0]           alu_out_select,
    output logic [1:0]           alu_load_src,
    output logic                 alu_store_to_stk,
    output logic                 alu_store_to_mem
);

    // Valid-only input: no ready/stall, a word is registered every cycle and
    // instr_valid = 0 registers the NOP word.
    logic             offset;
    logic             invert;
    logic [1:0]       cond;
    logic [SEL_W-1:0] test_idx;
    logic [SEL_W-1:0] reg_idx;
    logic             flag;
    logic             take;
    logic [CW_W-1:0]  next_word;

    assign offset   = instruction[11];
    assign invert   = instruction[10];
    assign cond     = instruction[9:8];
    assign test_idx = instruction[4 +: SEL_W];
    assign reg_idx  = instruction[0 +: SEL_W];

`ifndef JCU_ERROR_COND_EN
    logic unused_errorbit;
    assign unused_errorbit = ^errorbit;
`endif

    always_comb begin
        flag = 1'b0;
        case (cond)
            COND_Z: flag = zeroflag[test_idx];
            COND_S: flag = signflag[test_idx];
            COND_O: flag = overflow[test_idx];
            COND_E: begin
`ifdef JCU_ERROR_COND_EN
                flag = errorbit[test_idx];
`else
                // Without error tracking cond 11 is an always-true test.
                flag = 1'b1;
`endif
            end
            default: flag = 1'b0;
        endcase
    end

    assign take = flag ^ invert;

    always_comb begin
        next_word = CW_NOP;
        if (instr_valid) begin
            next_word = pack_word(~take,
                                  offset ? ALU_IADD : ALU_LEFT,
                                  16'h0, 16'h0,
                                  4'(reg_idx), 4'h0,
                                  1'b0, 1'b0,
                                  4'h0,
                                  take ? LD_PC : LD_NONE,
                                  1'b0, 1'b0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_word <= CW_NOP;
        end else begin
            control_word <= next_word;
        end
    end

    jcu_word_unpack u_unpack (
        .word                      (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_stk          (alu_store_to_stk),
        .alu_store_to_mem          (alu_store_to_mem)
    );

endmodule

// File: tb/tb_jump_control_unit.sv
// Self-checking bench for jump_control_unit: directed cases, async reset,
// randomized stimulus and back-to-back traffic against a behavioural model.
`timescale 1ns/1ps
module tb_jump_control_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [11:0] instruction;
    logic [15:0] zeroflag, signflag, overflow, errorbit;
    logic [54:0] control_word;
    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [15:0] alu_a_altern, alu_b_altern;
    logic [3:0]  alu_a_select, alu_b_select;
    logic        alu_a_source, alu_b_source;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_stk, alu_store_to_mem;

    int checks = 0;
    int errors = 0;
    logic [54:0] exp_q[$];

    localparam logic [54:0] NOP_WORD = 55'h40_0000_0000_0000;

    jump_control_unit dut (
        .clk                       (clk),
        .rst                       (rst),
        .instr_valid               (instr_valid),
        .instruction               (instruction),
        .zeroflag                  (zeroflag),
        .signflag                  (signflag),
        .overflow                  (overflow),
        .errorbit                  (errorbit),
        .control_word              (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_stk          (alu_store_to_stk),
        .alu_store_to_mem          (alu_store_to_mem)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decide jump from the chosen flag, then lay out fields.
    function automatic logic [54:0] model_word(input logic v, input logic [11:0] ins,
                                               input logic [15:0] z, input logic [15:0] s,
                                               input logic [15:0] o, input logic [15:0] e);
        int t;
        logic flag, take;
        logic [3:0] op;
        if (!v) return NOP_WORD;
        t = int'(ins[7:4]);
        case (ins[9:8])
            2'd0: flag = z[t];
            2'd1: flag = s[t];
            2'd2: flag = o[t];
            default: begin
`ifdef JCU_ERROR_COND_EN
                flag = e[t];
`else
                flag = 1'b1;
`endif
            end
        endcase
        take = flag ^ ins[10];
        op = ins[11] ? 4'd1 : 4'd0;
        return {~take, op, 16'd0, 16'd0, ins[3:0], 4'd0, 1'b0, 1'b0, 4'd0,
                take ? 2'b01 : 2'b00, 1'b0, 1'b0};
    endfunction

    // Driver: present inputs, let one edge pass, sample 1ns later.
    task automatic drive_cycle(input logic v, input logic [11:0] ins);
        instr_valid = v;
        instruction = ins;
        exp_q.push_back(model_word(v, ins, zeroflag, signflag, overflow, errorbit));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        instruction = 12'h456;
        zeroflag = 16'h5555; signflag = '0; overflow = '0; errorbit = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (control_word !== NOP_WORD) begin
            errors++;
            $display("FAIL reset_word: got %h expected %h", control_word, NOP_WORD);
        end
        checks++;
        if (program_counter_increment !== 1'b1 || alu_load_src !== 2'b00 || alu_a_select !== 4'h0) begin
            errors++;
            $display("FAIL reset_fields: pc_inc %b load %b a_sel %h expected 1 00 0",
                     program_counter_increment, alu_load_src, alu_a_select);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [11:0] ins_t[9];
        logic [15:0] z_t[9], s_t[9], o_t[9];
        logic        pc_t[9];
        logic [3:0]  op_t[9];
        logic [54:0] exp;
        ins_t = '{12'h056, 12'h456, 12'h856, 12'hC56, 12'h13A, 12'h14A, 12'h2F2, 12'h301, 12'h701};
        z_t   = '{16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        s_t   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0008, 16'h0008, 16'h0, 16'h0, 16'h0};
        o_t   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0};
        op_t  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
`ifdef JCU_ERROR_COND_EN
        pc_t  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        pc_t  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 9; i++) begin
            zeroflag = z_t[i]; signflag = s_t[i]; overflow = o_t[i]; errorbit = 16'h0;
            drive_cycle(1'b1, ins_t[i]);
            exp = exp_q.pop_front();
            checks++;
            if (program_counter_increment !== pc_t[i] || alu_op !== op_t[i] ||
                alu_a_select !== ins_t[i][3:0] || alu_b_select !== 4'h0 ||
                alu_out_select !== 4'h0 || alu_load_src !== (pc_t[i] ? 2'b00 : 2'b01)) begin
                errors++;
                $display("FAIL directed_%0d: pc %b op %h a %h b %h out %h ld %b expected pc %b op %h a %h",
                         i, program_counter_increment, alu_op, alu_a_select, alu_b_select,
                         alu_out_select, alu_load_src, pc_t[i], op_t[i], ins_t[i][3:0]);
            end
            checks++;
            if (control_word !== exp) begin
                errors++;
                $display("FAIL directed_word_%0d: got %h expected %h", i, control_word, exp);
            end
        end
    endtask

    task automatic test_nop();
        zeroflag = 16'hFFFF;
        drive_cycle(1'b0, 12'h401);
        void'(exp_q.pop_front());
        checks++;
        if (control_word !== NOP_WORD) begin
            errors++;
            $display("FAIL invalid_nop: got %h expected %h", control_word, NOP_WORD);
        end
    endtask

    task automatic test_async_reset();
        zeroflag = 16'h0000;
        drive_cycle(1'b1, 12'h4A7);
        void'(exp_q.pop_front());
        checks++;
        if (alu_load_src !== 2'b01 || program_counter_increment !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_jump: ld %b pc %b expected 01 0", alu_load_src, program_counter_increment);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (control_word !== NOP_WORD) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", control_word, NOP_WORD);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 12'h4A7);
        checks++;
        if (control_word !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL first_after_reset: got %h", control_word);
        end
    endtask

    task automatic test_random();
        logic [54:0] exp;
        for (int i = 0; i < 300; i++) begin
            zeroflag = 16'($urandom); signflag = 16'($urandom);
            overflow = 16'($urandom); errorbit = 16'($urandom);
            drive_cycle($urandom_range(0, 7) != 0, 12'($urandom));
            exp = exp_q.pop_front();
            checks++;
            if (control_word !== exp) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, control_word, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [54:0] exp;
        logic [54:0] cat;
        for (int i = 0; i < 64; i++) begin
            zeroflag = 16'($urandom);
            drive_cycle(1'b1, {1'b0, i[0], 2'b00, 4'($urandom), 4'($urandom)});
            exp = exp_q.pop_front();
            cat = {program_counter_increment, alu_op, alu_a_altern, alu_b_altern,
                   alu_a_select, alu_b_select, alu_a_source, alu_b_source,
                   alu_out_select, alu_load_src, alu_store_to_stk, alu_store_to_mem};
            checks++;
            if (control_word !== exp || cat !== exp) begin
                errors++;
                $display("FAIL b2b_%0d: word %h fields %h expected %h", i, control_word, cat, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        zeroflag = '0; signflag = '0; overflow = '0; errorbit = '0;
        test_reset();
        test_directed();
        test_nop();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
